rot_sweep_seq: RTL and testbench
================================

# rot_sweep_seq

Sequencer that sits directly in front of the 8-bit `barrel_shifter` (rotate-left) and consumes its result. It accepts one rotation job per handshake: a byte, a start shift, a stride and an output count. It steps the shifter's `data_in` and `shifts` inputs through the sweep and streams each rotated byte out on a valid/ready interface with a last-beat marker. The `barrel_shifter` instance stays purely combinational; this block owns all sequencing and buffering around it.

## Interface
- No parameters. The datapath is fixed at 8 bits and the shift field at 3 bits, matching the `barrel_shifter` instance.
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  job offered
- `in_ready`  out  1  job accepted when `in_valid && in_ready`
- `in_data`  in  8  byte to rotate
- `in_start`  in  3  first rotate-left amount
- `in_stride`  in  3  increment added to the shift after each beat, mod 8
- `in_count`  in  3  number of output beats minus 1 (1..8 beats)
- `sh_data`  out  8  to `barrel_shifter.data_in`
- `sh_shifts`  out  3  to `barrel_shifter.shifts`
- `sh_result`  in  8  from `barrel_shifter.data_out` (combinational return)
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  downstream accepts
- `out_data`  out  8  rotated byte
- `out_shift`  out  3  shift amount that produced `out_data`
- `out_last`  out  1  final beat of the job
- `busy`  out  1  high while state is RUN

## Operation
- Two states: IDLE and RUN.
- `in_ready = (state == IDLE)`.
- `busy = (state == RUN)`.
- **IDLE, on accept:**
  - Register `sh_data <= in_data`, `sh_shifts <= in_start`, `rem <= in_count`, `stride <= in_stride`.
  - Go to RUN.
- **RUN, issue condition:** `!out_valid || out_ready`. When it holds:
  - Load `out_data <= sh_result`, `out_shift <= sh_shifts`, `out_last <= (rem == 0)`, `out_valid <= 1`.
  - If `rem == 0`, go to IDLE.
  - Otherwise `sh_shifts <= sh_shifts + stride` (3-bit wrap) and `rem <= rem - 1`.
- **RUN, issue condition false** (`out_valid && !out_ready`): all registers hold. `sh_data` and `sh_shifts` stay stable, so the shifter output stays stable.
- **Any state:** when `out_valid && out_ready` and no new beat is issued that cycle, `out_valid <= 0`.
- A new job can be accepted while the last beat of the previous job is still waiting in the output register. The next job's first issue waits on the normal issue condition.
- `sh_data` is held after a job completes (no clear). `sh_shifts` holds its last value.
- Stride 0 is legal: every beat of the job uses the same shift.
- Wrap-around: the shift sequence is computed mod 8 (e.g. 7 + 3 -> 2).
- The output register is a single entry. No beat is dropped or duplicated under any `out_ready` pattern.

## Timing
- Reset (async, immediate):
  - state = IDLE, so `in_ready = 1` and `busy = 0`.
  - `out_valid = 0`, `out_data = 0x00`, `out_shift = 0`, `out_last = 0`.
  - `sh_data = 0x00`, `sh_shifts = 0`, `rem = 0`, `stride = 0`.
- Accept at edge N. The first beat is visible (`out_valid = 1`) after edge N+1. Latency from accept to first beat is 1 cycle.
- With `out_ready` held high, one beat per cycle.
- A job of k beats occupies RUN for k cycles.
- `in_ready` returns high after the edge that issues the last beat. Back-to-back jobs of k beats therefore cost k+1 cycles each.
- Reset asserted mid-job: the job is discarded and `out_valid` falls immediately, without waiting for a clock edge. After `rst_n` rises, the block accepts on the first edge where `in_valid` is high.
- Simultaneous last-beat issue and downstream accept of the previous beat: the new beat replaces the old one; `out_valid` stays 1.

## Test plan
- **Basic sweep:** `in_data = 0xB4`, start 0, stride 1, count 3, `out_ready = 1`.
  - Expect `out_data` 0xB4, 0x69, 0xD2, 0xA5 on consecutive cycles, with `out_shift` 0, 1, 2, 3.
  - `out_last` high only on 0xA5. `in_ready` low for 4 cycles.
- **Wrap-around:** `0xB4`, start 6, stride 3, count 2.
  - Expect shifts 6, 1, 4 and data 0x2D, 0x69, 0x4B. `out_last` on 0x4B.
- **Backpressure:** basic sweep job with `out_ready` pattern 1, 0, 0, 1, 0, 1, 1.
  - Expect exactly four beats in order 0xB4, 0x69, 0xD2, 0xA5.
  - `out_data`, `out_shift` and `sh_shifts` stable while stalled. No duplicates.
- **Stride 0, max count:** `0x81`, start 1, stride 0, count 7.
  - Expect eight beats of 0x03 with `out_shift = 1`. `out_last` on the 8th beat.
- **Back-to-back:** `in_valid` held high with job A (`0x01`, start 0, stride 1, count 0) and job B (`0x01`, start 7, stride 1, count 1).
  - Expect beats 0x01 (last), then 0x80, then 0x01 (last).
  - B accepted 1 cycle after A's beat is issued.
- **Reset mid-job:** pull `rst_n` low during beat 2 of the basic sweep.
  - Expect `out_valid = 0`, `in_ready = 1` and `busy = 0` immediately.
  - After release, a fresh job (`0xB4`, start 4, stride 1, count 0) yields a single beat 0x4B with `out_last = 1`.

Source files
------------

// File: rtl/rot_sweep_seq.sv
// rtl/rot_sweep_seq.sv - rotation sweep sequencer wrapped around an 8-bit rotate-left barrel shifter
module rot_sweep_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_start,
    input  logic [2:0] in_stride,
    input  logic [2:0] in_count,
    output logic [7:0] sh_data,
    output logic [2:0] sh_shifts,
    input  logic [7:0] sh_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [2:0] out_shift,
    output logic       out_last,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] rem;
    logic [2:0] stride;
    logic       issue;

    assign in_ready = (state == IDLE);
    assign busy     = (state == RUN);
    // A beat may be issued when the single output slot is empty or draining this cycle.
    assign issue    = (state == RUN) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh_data   <= 8'h00;
            sh_shifts <= 3'd0;
            rem       <= 3'd0;
            stride    <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_shift <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_data   <= in_data;
                        sh_shifts <= in_start;
                        rem       <= in_count;
                        stride    <= in_stride;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        out_data  <= sh_result;
                        out_shift <= sh_shifts;
                        out_last  <= (rem == 3'd0);
                        out_valid <= 1'b1;
                        if (rem == 3'd0) begin
                            state <= IDLE;
                        end else begin
                            sh_shifts <= sh_shifts + stride;
                            rem       <= rem - 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_sweep_seq.sv
// tb/tb_rot_sweep_seq.sv - self-checking bench for rot_sweep_seq with a behavioural shifter and sweep model
module tb_rot_sweep_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_start;
    logic [2:0] in_stride;
    logic [2:0] in_count;
    logic [7:0] sh_data;
    logic [2:0] sh_shifts;
    logic [7:0] sh_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_shift;
    logic       out_last;
    logic       busy;

    int n_cmp;
    int n_fail;

    logic [7:0] cap_data[$];
    logic [2:0] cap_shift[$];
    logic       cap_last[$];
    int         stall_changes;
    int         busy_cycles;
    logic       timed_out;

    rot_sweep_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_start  (in_start),
        .in_stride (in_stride),
        .in_count  (in_count),
        .sh_data   (sh_data),
        .sh_shifts (sh_shifts),
        .sh_result (sh_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Combinational barrel shifter sitting behind the sequencer.
    assign sh_result = 8'(({8'h00, sh_data, sh_data} << sh_shifts) >> 8);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] d, input int s);
        int v;
        v = ((int'(d) << s) | (int'(d) >> (8 - s))) & 255;
        return v[7:0];
    endfunction

    function automatic int exp_shift(input int st, input int sr, input int i);
        return (st + i * sr) % 8;
    endfunction

    // Drives one job and records every accepted output beat; mode 0 = ready high,
    // 1 = ready from pat (LSB first), 2 = random ready.
    task automatic run_job(input logic [7:0] d, input logic [2:0] st, input logic [2:0] sr,
                           input logic [2:0] cnt, input int mode, input logic [15:0] pat);
        int         cyc;
        logic       done;
        logic       stalled;
        logic [7:0] pd;
        logic [2:0] ps;
        logic [2:0] pss;
        cap_data.delete();
        cap_shift.delete();
        cap_last.delete();
        stall_changes = 0;
        busy_cycles   = 0;
        timed_out     = 1'b0;
        in_data   = d;
        in_start  = st;
        in_stride = sr;
        in_count  = cnt;
        in_valid  = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) timed_out = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done    = 1'b0;
        stalled = 1'b0;
        pd  = '0;
        ps  = '0;
        pss = '0;
        cyc = 0;
        while (!done && cyc < 200) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc < 16) ? pat[cyc] : 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (!in_ready) busy_cycles++;
            if (stalled && (out_data !== pd || out_shift !== ps || sh_shifts !== pss))
                stall_changes++;
            stalled = out_valid && !out_ready;
            pd  = out_data;
            ps  = out_shift;
            pss = sh_shifts;
            if (out_valid && out_ready) begin
                cap_data.push_back(out_data);
                cap_shift.push_back(out_shift);
                cap_last.push_back(out_last);
                if (out_last) done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) timed_out = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_cmp++; if (out_shift !== 3'd0) begin n_fail++; $display("FAIL reset_out_shift got %0d want 0", out_shift); end
        n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_cmp++; if (sh_data !== 8'h00) begin n_fail++; $display("FAIL reset_sh_data got %h want 00", sh_data); end
        n_cmp++; if (sh_shifts !== 3'd0) begin n_fail++; $display("FAIL reset_sh_shifts got %0d want 0", sh_shifts); end
    endtask

    task automatic test_basic_sweep();
        logic [7:0] ed[4];
        ed[0] = 8'hB4; ed[1] = 8'h69; ed[2] = 8'hD2; ed[3] = 8'hA5;
        run_job(8'hB4, 3'd0, 3'd1, 3'd3, 0, 16'h0000);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got 1 want 0"); end
        n_cmp++; if (cap_data.size() != 4) begin n_fail++; $display("FAIL basic_beats got %0d want 4", cap_data.size()); end
        for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
            n_cmp++; if (cap_data[i] !== ed[i]) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, cap_data[i], ed[i]); end
            n_cmp++; if (cap_shift[i] !== 3'(i)) begin n_fail++; $display("FAIL basic_shift[%0d] got %0d want %0d", i, cap_shift[i], i); end
            n_cmp++; if (cap_last[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", i, cap_last[i], i == 3); end
        end
        n_cmp++; if (busy_cycles != 4) begin n_fail++; $display("FAIL basic_in_ready_low got %0d want 4", busy_cycles); end
    endtask

    task automatic test_wrap();
        logic [7:0] ed[3];
        logic [2:0] es[3];
        ed[0] = 8'h2D; ed[1] = 8'h69; ed[2] = 8'h4B;
        es[0] = 3'd6;  es[1] = 3'd1;  es[2] = 3'd4;
        run_job(8'hB4, 3'd6, 3'd3, 3'd2, 0, 16'h0000);
        n_cmp++; if (cap_data.size() != 3 || timed_out) begin n_fail++; $display("FAIL wrap_beats got %0d want 3", cap_data.size()); end
        for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
            n_cmp++; if (cap_data[i] !== ed[i]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, cap_data[i], ed[i]); end
            n_cmp++; if (cap_shift[i] !== es[i]) begin n_fail++; $display("FAIL wrap_shift[%0d] got %0d want %0d", i, cap_shift[i], es[i]); end
            n_cmp++; if (cap_last[i] !== (i == 2)) begin n_fail++; $display("FAIL wrap_last[%0d] got %b want %b", i, cap_last[i], i == 2); end
        end
    endtask

    task automatic test_backpressure();
        // ready pattern 1,0,0,1,0,1,1 then held high
        run_job(8'hB4, 3'd0, 3'd1, 3'd3, 1, 16'hFFE9);
        n_cmp++; if (cap_data.size() != 4 || timed_out) begin n_fail++; $display("FAIL bp_beats got %0d want 4", cap_data.size()); end
        for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
            n_cmp++; if (cap_data[i] !== rotl(8'hB4, i)) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, cap_data[i], rotl(8'hB4, i)); end
            n_cmp++; if (cap_last[i] !== (i == 3)) begin n_fail++; $display("FAIL bp_last[%0d] got %b want %b", i, cap_last[i], i == 3); end
        end
        n_cmp++; if (stall_changes != 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_changes); end
    endtask

    task automatic test_stride0_max();
        run_job(8'h81, 3'd1, 3'd0, 3'd7, 0, 16'h0000);
        n_cmp++; if (cap_data.size() != 8 || timed_out) begin n_fail++; $display("FAIL s0_beats got %0d want 8", cap_data.size()); end
        for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
            n_cmp++; if (cap_data[i] !== 8'h03 || cap_shift[i] !== 3'd1) begin n_fail++; $display("FAIL s0_beat[%0d] got %h/%0d want 03/1", i, cap_data[i], cap_shift[i]); end
            n_cmp++; if (cap_last[i] !== (i == 7)) begin n_fail++; $display("FAIL s0_last[%0d] got %b want %b", i, cap_last[i], i == 7); end
        end
        n_cmp++; if (busy_cycles != 8) begin n_fail++; $display("FAIL s0_run_cycles got %0d want 8", busy_cycles); end
    endtask

    task automatic test_back_to_back();
        int         cyc;
        int         acc_a;
        int         acc_b;
        logic [7:0] ed[3];
        logic [2:0] es[3];
        logic       el[3];
        ed[0] = 8'h01; ed[1] = 8'h80; ed[2] = 8'h01;
        es[0] = 3'd0;  es[1] = 3'd7;  es[2] = 3'd0;
        el[0] = 1'b1;  el[1] = 1'b0;  el[2] = 1'b1;
        cap_data.delete();
        cap_shift.delete();
        cap_last.delete();
        out_ready = 1'b1;
        in_data = 8'h01; in_start = 3'd0; in_stride = 3'd1; in_count = 3'd0;
        in_valid = 1'b1;
        acc_a = -1;
        acc_b = -1;
        cyc = 0;
        while (cap_data.size() < 3 && cyc < 50) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                cap_data.push_back(out_data);
                cap_shift.push_back(out_shift);
                cap_last.push_back(out_last);
            end
            if (in_ready && in_valid) begin
                if (acc_a < 0) acc_a = cyc;
                else if (acc_b < 0) acc_b = cyc;
            end
            @(posedge clk);
            #1;
            if (acc_b >= 0) in_valid = 1'b0;
            else if (acc_a >= 0) begin
                in_data = 8'h01; in_start = 3'd7; in_stride = 3'd1; in_count = 3'd1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++; if (cap_data.size() != 3) begin n_fail++; $display("FAIL b2b_beats got %0d want 3", cap_data.size()); end
        for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
            n_cmp++; if (cap_data[i] !== ed[i] || cap_shift[i] !== es[i] || cap_last[i] !== el[i])
                begin n_fail++; $display("FAIL b2b_beat[%0d] got %h/%0d/%b want %h/%0d/%b", i, cap_data[i], cap_shift[i], cap_last[i], ed[i], es[i], el[i]); end
        end
        n_cmp++; if (acc_b - acc_a != 2) begin n_fail++; $display("FAIL b2b_accept_gap got %0d want 2", acc_b - acc_a); end
    endtask

    task automatic test_reset_mid_job();
        out_ready = 1'b1;
        in_data = 8'hB4; in_start = 3'd0; in_stride = 3'd1; in_count = 3'd3;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h69) begin n_fail++; $display("FAIL rst_pre_beat2 got %b/%h want 1/69", out_valid, out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_in_ready got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(8'hB4, 3'd4, 3'd1, 3'd0, 0, 16'h0000);
        n_cmp++; if (cap_data.size() != 1 || timed_out) begin n_fail++; $display("FAIL rst_fresh_beats got %0d want 1", cap_data.size()); end
        if (cap_data.size() >= 1) begin
            n_cmp++; if (cap_data[0] !== 8'h4B || cap_last[0] !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_beat got %h/%b want 4B/1", cap_data[0], cap_last[0]); end
        end
    endtask

    task automatic test_random_jobs();
        logic [7:0] d;
        logic [2:0] st;
        logic [2:0] sr;
        logic [2:0] cnt;
        for (int j = 0; j < 12; j++) begin
            d   = 8'($urandom);
            st  = 3'($urandom);
            sr  = 3'($urandom);
            cnt = 3'($urandom);
            run_job(d, st, sr, cnt, 2, 16'h0000);
            n_cmp++; if (cap_data.size() != int'(cnt) + 1 || timed_out) begin n_fail++; $display("FAIL rnd%0d_beats got %0d want %0d", j, cap_data.size(), int'(cnt) + 1); end
            for (int i = 0; i <= int'(cnt) && i < cap_data.size(); i++) begin
                n_cmp++;
                if (cap_shift[i] !== 3'(exp_shift(st, sr, i)) || cap_data[i] !== rotl(d, exp_shift(st, sr, i)) || cap_last[i] !== (i == int'(cnt))) begin
                    n_fail++;
                    $display("FAIL rnd%0d_beat[%0d] got %h/%0d/%b want %h/%0d/%b", j, i, cap_data[i], cap_shift[i], cap_last[i],
                             rotl(d, exp_shift(st, sr, i)), exp_shift(st, sr, i), i == int'(cnt));
                end
            end
            n_cmp++; if (stall_changes != 0) begin n_fail++; $display("FAIL rnd%0d_stall_stable got %0d want 0", j, stall_changes); end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_start  = 3'd0;
        in_stride = 3'd0;
        in_count  = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic_sweep();
        test_wrap();
        test_backpressure();
        test_stride0_max();
        test_back_to_back();
        test_reset_mid_job();
        test_random_jobs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
